// File: rtl/rs_multi_cdb_if.sv
// rtl/rs_multi_cdb_if.sv - issue, broadcast, execute and status bundle for rs_multi_cdb
//
// Purpose: bundles every non-clock/reset signal of the reservation station.
// Port summary (direction seen from the reservation station, modport slave):
//   in : rdy_in, clear, iss_valid, iss_op, iss_vj, iss_vk, iss_dj, iss_dk,
//        iss_qj, iss_qk, iss_rob_id, cdb_valid, cdb_rob_id, cdb_value, ex_ready
//   out: rs_full, ex_valid, ex_op, ex_lhs, ex_rhs, ex_rob_id, count
// modport master is the mirror image (decoder / CDB / ALU side).
interface rs_multi_cdb_if #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 4,
  parameter int NUM_CDB   = 2,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 8
);
  localparam int CW = $clog2(RS_SIZE + 1);

  logic                          rdy_in;
  logic                          clear;
  logic                          iss_valid;
  logic                          rs_full;
  logic [OP_W-1:0]               iss_op;
  logic [DATA_W-1:0]             iss_vj;
  logic [DATA_W-1:0]             iss_vk;
  logic                          iss_dj;
  logic                          iss_dk;
  logic [ROB_WIDTH-1:0]          iss_qj;
  logic [ROB_WIDTH-1:0]          iss_qk;
  logic [ROB_WIDTH-1:0]          iss_rob_id;
  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB*ROB_WIDTH-1:0]  cdb_rob_id;
  logic [NUM_CDB*DATA_W-1:0]     cdb_value;
  logic                          ex_valid;
  logic                          ex_ready;
  logic [OP_W-1:0]               ex_op;
  logic [DATA_W-1:0]             ex_lhs;
  logic [DATA_W-1:0]             ex_rhs;
  logic [ROB_WIDTH-1:0]          ex_rob_id;
  logic [CW-1:0]                 count;

  modport master (
    output rdy_in, clear, iss_valid, iss_op, iss_vj, iss_vk, iss_dj, iss_dk,
           iss_qj, iss_qk, iss_rob_id, cdb_valid, cdb_rob_id, cdb_value, ex_ready,
    input  rs_full, ex_valid, ex_op, ex_lhs, ex_rhs, ex_rob_id, count
  );

  modport slave (
    input  rdy_in, clear, iss_valid, iss_op, iss_vj, iss_vk, iss_dj, iss_dk,
           iss_qj, iss_qk, iss_rob_id, cdb_valid, cdb_rob_id, cdb_value, ex_ready,
    output rs_full, ex_valid, ex_op, ex_lhs, ex_rhs, ex_rob_id, count
  );
endinterface

// File: rtl/rs_multi_cdb.sv
// rtl/rs_multi_cdb.sv - oldest-first reservation station snooping NUM_CDB broadcast channels
//
// Purpose: holds up to RS_SIZE decoded ALU ops, wakes operands from the CDB channels
// (with bypass at issue), and dispatches the oldest ready entry into a registered
// valid/ready execute port that tolerates back-pressure.
// Ports:
//   clk_in  in  system clock
//   rst_in  in  asynchronous active-high reset
//   bus     rs_multi_cdb_if.slave (issue, CDB, execute port, rs_full, count, rdy_in, clear)
module rs_multi_cdb #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 4,
  parameter int NUM_CDB   = 2,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  rs_multi_cdb_if.slave bus
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CW = $clog2(RS_SIZE + 1);

  // entry storage
  logic [RS_SIZE-1:0]   busy_q, busy_d, dj_q, dj_d, dk_q, dk_d;
  logic [OP_W-1:0]      op_q  [RS_SIZE];
  logic [OP_W-1:0]      op_d  [RS_SIZE];
  logic [DATA_W-1:0]    vj_q  [RS_SIZE];
  logic [DATA_W-1:0]    vj_d  [RS_SIZE];
  logic [DATA_W-1:0]    vk_q  [RS_SIZE];
  logic [DATA_W-1:0]    vk_d  [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_d  [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_d  [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_q [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_d [RS_SIZE];
  // older_q[i][j] = 1 means entry i was issued before entry j
  logic [RS_SIZE-1:0]   older_q [RS_SIZE];
  logic [RS_SIZE-1:0]   older_d [RS_SIZE];

  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]      ex_op_q, ex_op_d;
  logic [DATA_W-1:0]    ex_lhs_q, ex_lhs_d;
  logic [DATA_W-1:0]    ex_rhs_q, ex_rhs_d;
  logic [ROB_WIDTH-1:0] ex_rob_q, ex_rob_d;

  // CDB match results for stored entries and for the op being issued
  logic [RS_SIZE-1:0]   wj_hit, wk_hit;
  logic [DATA_W-1:0]    wj_val [RS_SIZE];
  logic [DATA_W-1:0]    wk_val [RS_SIZE];
  logic                 ij_hit, ik_hit;
  logic [DATA_W-1:0]    ij_val, ik_val;

  logic [RS_SIZE-1:0]   ready, sel_oh;
  logic [IW-1:0]        sel_idx, free_idx;
  logic                 any_ready, free_found;
  logic                 iss_acc, disp_ok, disp;

  // Channels scanned from highest to lowest so the lowest matching channel wins.
  always_comb begin
    wj_hit = '0;
    wk_hit = '0;
    ij_hit = 1'b0;
    ik_hit = 1'b0;
    ij_val = '0;
    ik_val = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      wj_val[i] = '0;
      wk_val[i] = '0;
    end
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (bus.cdb_valid[c]) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (bus.cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == qj_q[i]) begin
            wj_hit[i] = 1'b1;
            wj_val[i] = bus.cdb_value[c*DATA_W +: DATA_W];
          end
          if (bus.cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == qk_q[i]) begin
            wk_hit[i] = 1'b1;
            wk_val[i] = bus.cdb_value[c*DATA_W +: DATA_W];
          end
        end
        if (bus.cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == bus.iss_qj) begin
          ij_hit = 1'b1;
          ij_val = bus.cdb_value[c*DATA_W +: DATA_W];
        end
        if (bus.cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == bus.iss_qk) begin
          ik_hit = 1'b1;
          ik_val = bus.cdb_value[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Oldest-first select: keep a ready entry only if it is older than every other ready one.
  always_comb begin
    ready  = busy_q & ~dj_q & ~dk_q;
    sel_oh = ready;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j != i && ready[j] && !older_q[i][j]) sel_oh[i] = 1'b0;
      end
    end
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel_oh[i]) sel_idx = IW'(i);
    end
    any_ready = |ready;
  end

  // Lowest-index free slot, judged on registered busy bits only.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    dj_d       = dj_q;
    dk_d       = dk_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    rob_d      = rob_q;
    older_d    = older_q;
    count_d    = count_q;
    full_d     = full_q;
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_lhs_d   = ex_lhs_q;
    ex_rhs_d   = ex_rhs_q;
    ex_rob_d   = ex_rob_q;

    iss_acc = bus.rdy_in && !bus.clear && bus.iss_valid && !full_q;
    disp_ok = !ex_valid_q || bus.ex_ready;
    disp    = bus.rdy_in && !bus.clear && disp_ok && any_ready;

    if (bus.rdy_in) begin
      if (bus.clear) begin
        busy_d     = '0;
        count_d    = '0;
        full_d     = 1'b0;
        ex_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && dj_q[i] && wj_hit[i]) begin
            vj_d[i] = wj_val[i];
            dj_d[i] = 1'b0;
          end
          if (busy_q[i] && dk_q[i] && wk_hit[i]) begin
            vk_d[i] = wk_val[i];
            dk_d[i] = 1'b0;
          end
        end

        if (disp_ok) begin
          ex_valid_d = any_ready;
          if (any_ready) begin
            ex_op_d         = op_q[sel_idx];
            ex_lhs_d        = vj_q[sel_idx];
            ex_rhs_d        = vk_q[sel_idx];
            ex_rob_d        = rob_q[sel_idx];
            busy_d[sel_idx] = 1'b0;
          end
        end

        if (iss_acc) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = bus.iss_op;
          qj_d[free_idx]   = bus.iss_qj;
          qk_d[free_idx]   = bus.iss_qk;
          rob_d[free_idx]  = bus.iss_rob_id;
          vj_d[free_idx]   = (bus.iss_dj && ij_hit) ? ij_val : bus.iss_vj;
          vk_d[free_idx]   = (bus.iss_dk && ik_hit) ? ik_val : bus.iss_vk;
          dj_d[free_idx]   = bus.iss_dj && !ij_hit;
          dk_d[free_idx]   = bus.iss_dk && !ik_hit;
          // new entry is younger than everything currently held
          for (int j = 0; j < RS_SIZE; j++) begin
            older_d[j][free_idx] = busy_q[j];
            older_d[free_idx][j] = 1'b0;
          end
        end

        count_d = count_q + CW'(iss_acc) - CW'(disp);
        full_d  = (count_d == CW'(RS_SIZE));
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      dj_q       <= '0;
      dk_q       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        rob_q[i]   <= '0;
        older_q[i] <= '0;
      end
      count_q    <= '0;
      full_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_lhs_q   <= '0;
      ex_rhs_q   <= '0;
      ex_rob_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      dj_q       <= dj_d;
      dk_q       <= dk_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      rob_q      <= rob_d;
      older_q    <= older_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_lhs_q   <= ex_lhs_d;
      ex_rhs_q   <= ex_rhs_d;
      ex_rob_q   <= ex_rob_d;
    end
  end

  assign bus.rs_full   = full_q;
  assign bus.count     = count_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op     = ex_op_q;
  assign bus.ex_lhs    = ex_lhs_q;
  assign bus.ex_rhs    = ex_rhs_q;
  assign bus.ex_rob_id = ex_rob_q;

  // The decoder must never issue into a full station.
  issue_when_full_a: assert property (@(posedge clk_in) disable iff (rst_in)
    (bus.rdy_in && !bus.clear && bus.iss_valid) |-> !full_q);
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb/tb_rs_multi_cdb.sv - self-checking bench for rs_multi_cdb
module tb_rs_multi_cdb;
  localparam int RS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_multi_cdb_if #(.RS_SIZE(RS), .ROB_WIDTH(4), .NUM_CDB(2), .DATA_W(32), .OP_W(8)) bus_if ();
  rs_multi_cdb #(.RS_SIZE(RS), .ROB_WIDTH(4), .NUM_CDB(2), .DATA_W(32), .OP_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.rdy_in     = 1'b1;
    bus_if.clear      = 1'b0;
    bus_if.iss_valid  = 1'b0;
    bus_if.iss_op     = '0;
    bus_if.iss_vj     = '0;
    bus_if.iss_vk     = '0;
    bus_if.iss_dj     = 1'b0;
    bus_if.iss_dk     = 1'b0;
    bus_if.iss_qj     = '0;
    bus_if.iss_qk     = '0;
    bus_if.iss_rob_id = '0;
    bus_if.cdb_valid  = '0;
    bus_if.cdb_rob_id = '0;
    bus_if.cdb_value  = '0;
    bus_if.ex_ready   = 1'b1;
  endtask

  task automatic set_issue(input logic [7:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic dj, input logic dk, input logic [3:0] qj,
                           input logic [3:0] qk, input logic [3:0] rob);
    bus_if.iss_valid  = 1'b1;
    bus_if.iss_op     = op;
    bus_if.iss_vj     = vj;
    bus_if.iss_vk     = vk;
    bus_if.iss_dj     = dj;
    bus_if.iss_dk     = dk;
    bus_if.iss_qj     = qj;
    bus_if.iss_qk     = qk;
    bus_if.iss_rob_id = rob;
  endtask

  task automatic set_cdb(input logic [1:0] cv, input logic [3:0] t0, input logic [31:0] v0,
                         input logic [3:0] t1, input logic [31:0] v1);
    bus_if.cdb_valid  = cv;
    bus_if.cdb_rob_id = {t1, t0};
    bus_if.cdb_value  = {v1, v0};
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;
    logic [7:0]  op;
    logic [31:0] vj, vk;
    logic        dj, dk;
    logic [3:0]  qj, qk, rob;
    logic [1:0]  cv;
    logic [3:0]  t0;
    logic [31:0] c0;
    logic [3:0]  t1;
    logic [31:0] c1;
    logic        ev;
    logic [7:0]  eop;
    logic [31:0] elhs, erhs;
    logic [3:0]  erob;
    logic [3:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic dj, input logic dk,
                              input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob,
                              input logic [1:0] cv, input logic [3:0] t0, input logic [31:0] c0,
                              input logic [3:0] t1, input logic [31:0] c1, input logic ev,
                              input logic [7:0] eop, input logic [31:0] elhs,
                              input logic [31:0] erhs, input logic [3:0] erob,
                              input logic [3:0] ecnt);
    vec_t v;
    v.iv = iv; v.op = op; v.vj = vj; v.vk = vk; v.dj = dj; v.dk = dk;
    v.qj = qj; v.qk = qk; v.rob = rob; v.cv = cv; v.t0 = t0; v.c0 = c0;
    v.t1 = t1; v.c1 = c1; v.ev = ev; v.eop = eop; v.elhs = elhs; v.erhs = erhs;
    v.erob = erob; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t vecs[$];

  // ---------------- reference model (age-ordered queue) ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] vj, vk;
    logic        dj, dk;
    logic [3:0]  qj, qk, rob;
  } ment_t;

  ment_t       mq[$];
  logic        m_ev;
  logic [7:0]  m_op;
  logic [31:0] m_lhs, m_rhs;
  logic [3:0]  m_rob;

  function automatic logic cdb_hit(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    for (int c = 0; c < 2; c++) begin
      if (bus_if.cdb_valid[c] && bus_if.cdb_rob_id[c*4 +: 4] == tag) begin
        val = bus_if.cdb_value[c*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic        was_full;
    int          idx;
    logic [31:0] v;
    ment_t       e;
    if (!bus_if.rdy_in) return;
    if (bus_if.clear) begin
      mq.delete();
      m_ev = 1'b0;
      return;
    end
    was_full = (mq.size() == RS);
    if (!m_ev || bus_if.ex_ready) begin
      idx = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].dj && !mq[i].dk) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0) begin
        m_ev = 1'b1; m_op = mq[idx].op; m_lhs = mq[idx].vj; m_rhs = mq[idx].vk;
        m_rob = mq[idx].rob;
        mq.delete(idx);
      end else begin
        m_ev = 1'b0;
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].dj && cdb_hit(mq[i].qj, v)) begin mq[i].vj = v; mq[i].dj = 1'b0; end
      if (mq[i].dk && cdb_hit(mq[i].qk, v)) begin mq[i].vk = v; mq[i].dk = 1'b0; end
    end
    if (bus_if.iss_valid && !was_full) begin
      e.op = bus_if.iss_op; e.qj = bus_if.iss_qj; e.qk = bus_if.iss_qk;
      e.rob = bus_if.iss_rob_id;
      e.vj = bus_if.iss_vj; e.dj = bus_if.iss_dj;
      e.vk = bus_if.iss_vk; e.dk = bus_if.iss_dk;
      if (e.dj && cdb_hit(e.qj, v)) begin e.vj = v; e.dj = 1'b0; end
      if (e.dk && cdb_hit(e.qk, v)) begin e.vk = v; e.dk = 1'b0; end
      mq.push_back(e);
    end
  endtask

  initial begin
    idle_inputs();

    vecs.push_back(mk(1, 8'h01, 3, 4, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 8'h01, 3, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 9, 1, 0, 5, 0, 2, 2'b10, 0, 0, 5, 32'h77, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 8'h02, 32'h77, 9, 2, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 1, 1, 6, 7, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 6, 32'hA, 7, 32'hB, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 8'h03, 32'hA, 32'hB, 3, 0));
    vecs.push_back(mk(1, 8'h04, 0, 5, 1, 0, 8, 0, 4, 2'b11, 8, 32'h11, 8, 32'h22, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 8'h04, 32'h11, 5, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset values
    do_reset();
    chk("rst_ex_valid", bus_if.ex_valid, 0);
    chk("rst_count", bus_if.count, 0);
    chk("rst_full", bus_if.rs_full, 0);
    chk("rst_ex_op", bus_if.ex_op, 0);
    chk("rst_ex_lhs", bus_if.ex_lhs, 0);

    // table: simple dispatch, issue bypass, wakeup from both channels, lowest channel wins
    for (int r = 0; r < vecs.size(); r++) begin
      idle_inputs();
      if (vecs[r].iv)
        set_issue(vecs[r].op, vecs[r].vj, vecs[r].vk, vecs[r].dj, vecs[r].dk,
                  vecs[r].qj, vecs[r].qk, vecs[r].rob);
      set_cdb(vecs[r].cv, vecs[r].t0, vecs[r].c0, vecs[r].t1, vecs[r].c1);
      tick();
      chk($sformatf("vec%0d_ex_valid", r), bus_if.ex_valid, vecs[r].ev);
      chk($sformatf("vec%0d_count", r), bus_if.count, vecs[r].ecnt);
      chk($sformatf("vec%0d_full", r), bus_if.rs_full, 0);
      if (vecs[r].ev) begin
        chk($sformatf("vec%0d_op", r), bus_if.ex_op, vecs[r].eop);
        chk($sformatf("vec%0d_lhs", r), bus_if.ex_lhs, vecs[r].elhs);
        chk($sformatf("vec%0d_rhs", r), bus_if.ex_rhs, vecs[r].erhs);
        chk($sformatf("vec%0d_rob", r), bus_if.ex_rob_id, vecs[r].erob);
      end
    end
    idle_inputs();

    // reset in the middle of a run, between clock edges
    do_reset();
    bus_if.ex_ready = 1'b0;
    set_issue(8'h10, 1, 2, 0, 0, 0, 0, 9);
    tick();
    bus_if.iss_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      set_issue(8'h20, 0, 0, 1, 0, 15, 0, 4'(i));
      tick();
    end
    bus_if.iss_valid = 1'b0;
    chk("midrst_pre_count", bus_if.count, 5);
    chk("midrst_pre_ex_valid", bus_if.ex_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_count", bus_if.count, 0);
    chk("midrst_ex_valid", bus_if.ex_valid, 0);
    chk("midrst_ex_op", bus_if.ex_op, 0);
    chk("midrst_full", bus_if.rs_full, 0);
    do_reset();

    // fill all entries waiting on tag 2, then release them in issue order
    bus_if.ex_ready = 1'b0;
    for (int i = 0; i < RS; i++) begin
      set_issue(8'(i), 0, 32'(i), 1, 0, 2, 0, 4'(i));
      tick();
    end
    bus_if.iss_valid = 1'b0;
    chk("fill_count", bus_if.count, RS);
    chk("fill_full", bus_if.rs_full, 1);
    chk("fill_ex_valid", bus_if.ex_valid, 0);
    set_cdb(2'b01, 2, 32'h200, 0, 0);
    tick();
    set_cdb(2'b00, 0, 0, 0, 0);
    chk("wake_ex_valid", bus_if.ex_valid, 0);
    chk("wake_count", bus_if.count, RS);
    tick();
    chk("age0_valid", bus_if.ex_valid, 1);
    chk("age0_rob", bus_if.ex_rob_id, 0);
    chk("age0_count", bus_if.count, RS - 1);
    chk("age0_full", bus_if.rs_full, 0);
    bus_if.ex_ready = 1'b1;
    for (int k = 1; k < RS; k++) begin
      tick();
      chk($sformatf("age%0d_rob", k), bus_if.ex_rob_id, 32'(k));
      chk($sformatf("age%0d_lhs", k), bus_if.ex_lhs, 32'h200);
      chk($sformatf("age%0d_rhs", k), bus_if.ex_rhs, 32'(k));
    end
    tick();
    chk("drain_ex_valid", bus_if.ex_valid, 0);
    chk("drain_count", bus_if.count, 0);

    // back-pressure holds the port; rdy_in low freezes everything
    do_reset();
    bus_if.ex_ready = 1'b0;
    set_issue(8'h33, 32'h55, 32'h66, 0, 0, 0, 0, 5);
    tick();
    set_issue(8'h34, 32'h57, 32'h68, 0, 0, 0, 0, 6);
    tick();
    bus_if.iss_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d_valid", k), bus_if.ex_valid, 1);
      chk($sformatf("bp%0d_rob", k), bus_if.ex_rob_id, 5);
      chk($sformatf("bp%0d_lhs", k), bus_if.ex_lhs, 32'h55);
      chk($sformatf("bp%0d_count", k), bus_if.count, 1);
    end
    bus_if.rdy_in   = 1'b0;
    bus_if.ex_ready = 1'b1;
    set_issue(8'h35, 1, 1, 0, 0, 0, 0, 7);
    set_cdb(2'b11, 0, 1, 0, 1);
    repeat (2) tick();
    chk("frz_valid", bus_if.ex_valid, 1);
    chk("frz_rob", bus_if.ex_rob_id, 5);
    chk("frz_count", bus_if.count, 1);
    idle_inputs();
    tick();
    chk("unfrz_rob", bus_if.ex_rob_id, 6);
    chk("unfrz_lhs", bus_if.ex_lhs, 32'h57);
    chk("unfrz_count", bus_if.count, 0);

    // clear with pending wakeup
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_issue(8'h40, 0, 0, 1, 0, 9, 0, 4'(i));
      tick();
    end
    chk("clr_pre_count", bus_if.count, 4);
    bus_if.clear = 1'b1;
    set_cdb(2'b01, 9, 32'h99, 0, 0);
    tick();
    idle_inputs();
    chk("clr_count", bus_if.count, 0);
    chk("clr_ex_valid", bus_if.ex_valid, 0);
    tick();
    chk("clr_ghost", bus_if.ex_valid, 0);
    set_issue(8'h41, 32'hC0, 32'hC1, 0, 0, 0, 0, 12);
    tick();
    idle_inputs();
    chk("clr_slot0", dut.busy_q, 8'h01);
    tick();
    chk("clr_after_valid", bus_if.ex_valid, 1);
    chk("clr_after_rob", bus_if.ex_rob_id, 12);

    // randomized run against the queue model
    do_reset();
    mq.delete();
    m_ev = 1'b0; m_op = '0; m_lhs = '0; m_rhs = '0; m_rob = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      bus_if.rdy_in   = ($urandom_range(9) != 0);
      bus_if.clear    = ($urandom_range(49) == 0);
      bus_if.ex_ready = ($urandom_range(2) != 0);
      if ($urandom_range(1) == 1 && mq.size() < RS)
        set_issue(8'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                  4'($urandom_range(7)), 4'($urandom_range(7)), 4'($urandom));
      set_cdb(2'($urandom), 4'($urandom_range(7)), $urandom, 4'($urandom_range(7)), $urandom);
      model_step();
      tick();
      chk("rnd_ex_valid", bus_if.ex_valid, m_ev);
      chk("rnd_count", bus_if.count, 32'(mq.size()));
      chk("rnd_full", bus_if.rs_full, (mq.size() == RS));
      if (m_ev) begin
        chk("rnd_op", bus_if.ex_op, m_op);
        chk("rnd_lhs", bus_if.ex_lhs, m_lhs);
        chk("rnd_rhs", bus_if.ex_rhs, m_rhs);
        chk("rnd_rob", bus_if.ex_rob_id, m_rob);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
